// File: rtl/logic_shift_pkg.sv
// rtl/logic_shift_pkg.sv - shared state encoding and step-size helper for the shift sequencer
package logic_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int max_step(input int shift_bit_num);
        return (1 << shift_bit_num) - 1;
    endfunction

endpackage

// File: rtl/logic_shift_sequencer_if.sv
// rtl/logic_shift_sequencer_if.sv - request/result handshake bundle for logic_shift_sequencer
interface logic_shift_sequencer_if #(
    parameter int BIT_NUM        = 16,
    parameter int AMOUNT_BIT_NUM = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BIT_NUM-1:0]        in_data;
    logic [AMOUNT_BIT_NUM-1:0] in_amount;
    logic                      in_is_right;
    logic                      out_valid;
    logic                      out_ready;
    logic [BIT_NUM-1:0]        out_data;
    logic                      busy;

    modport master (
        output in_valid, in_data, in_amount, in_is_right, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_is_right, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/logic_shift.sv
// rtl/logic_shift.sv - single-pass combinational logical shifter with zero fill
module logic_shift #(
    parameter int BIT_NUM       = 16,
    parameter int SHIFT_BIT_NUM = 3
) (
    input  logic [BIT_NUM-1:0]       data_in,
    input  logic [SHIFT_BIT_NUM-1:0] shift_bit_num,
    input  logic                     is_right_shift,
    output logic [BIT_NUM-1:0]       data_out
);

    assign data_out = is_right_shift ? (data_in >> shift_bit_num)
                                     : (data_in << shift_bit_num);

endmodule

// File: rtl/logic_shift_sequencer.sv
// rtl/logic_shift_sequencer.sv - splits a large shift request into bounded logic_shift passes
module logic_shift_sequencer
    import logic_shift_pkg::*;
#(
    parameter int BIT_NUM        = 16,
    parameter int SHIFT_BIT_NUM  = 3,
    parameter int AMOUNT_BIT_NUM = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    logic_shift_sequencer_if.slave  bus
);

    localparam int MAX_STEP = max_step(SHIFT_BIT_NUM);
    localparam logic [AMOUNT_BIT_NUM-1:0] MAX_STEP_A = AMOUNT_BIT_NUM'(MAX_STEP);
    localparam logic [AMOUNT_BIT_NUM-1:0] BIT_NUM_A  = AMOUNT_BIT_NUM'(BIT_NUM);

    state_t                    state_q, state_d;
    logic [BIT_NUM-1:0]        data_q, data_d;
    logic [AMOUNT_BIT_NUM-1:0] remaining_q, remaining_d;
    logic                      dir_q, dir_d;

    logic [AMOUNT_BIT_NUM-1:0] step_w;
    logic [AMOUNT_BIT_NUM-1:0] clamped_w;
    logic [BIT_NUM-1:0]        shifted_w;

    logic_shift #(
        .BIT_NUM       (BIT_NUM),
        .SHIFT_BIT_NUM (SHIFT_BIT_NUM)
    ) u_logic_shift (
        .data_in        (data_q),
        .shift_bit_num  (step_w[SHIFT_BIT_NUM-1:0]),
        .is_right_shift (dir_q),
        .data_out       (shifted_w)
    );

    // Anything at or beyond the word width shifts every bit out, so cap it there.
    assign clamped_w = (bus.in_amount > BIT_NUM_A) ? BIT_NUM_A : bus.in_amount;
    assign step_w    = (remaining_q > MAX_STEP_A) ? MAX_STEP_A : remaining_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d      = bus.in_data;
                    dir_d       = bus.in_is_right;
                    remaining_d = clamped_w;
                    state_d     = (clamped_w == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d      = shifted_w;
                remaining_d = remaining_q - step_w;
                if (remaining_q == step_w) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_logic_shift_sequencer.sv
// tb/tb_logic_shift_sequencer.sv - directed table-driven bench for logic_shift_sequencer
module tb_logic_shift_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic_shift_sequencer_if #(.BIT_NUM(16), .AMOUNT_BIT_NUM(5)) bus ();

    logic_shift_sequencer #(
        .BIT_NUM        (16),
        .SHIFT_BIT_NUM  (3),
        .AMOUNT_BIT_NUM (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  amount;
        logic        right;
        logic [15:0] expect_data;
        int          expect_cycles;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [15:0] d, input logic [4:0] a, input logic r);
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.in_amount   = a;
        bus.in_is_right = r;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        bus.out_ready = 1'b1;
        check({name, " in_ready_before"}, 32'(bus.in_ready), 32'd1);
        accept(v.data, v.amount, v.right);
        wait_out(cyc);
        check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(v.expect_cycles));
        check({name, " out_data"}, 32'(bus.out_data), 32'(v.expect_data));
        check({name, " busy"}, 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check({name, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({name, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int cyc;
        bit seen;
        checks   = 0;
        failures = 0;
        vecs[0] = '{16'hB3C5, 5'd10, 1'b0, 16'h1400, 2};
        vecs[1] = '{16'h8001, 5'd9,  1'b1, 16'h0040, 2};
        vecs[2] = '{16'hA5A5, 5'd0,  1'b0, 16'hA5A5, 0};
        vecs[3] = '{16'hFFFF, 5'd31, 1'b0, 16'h0000, 3};
        vecs[4] = '{16'h1234, 5'd7,  1'b0, 16'h1A00, 1};
        vecs[5] = '{16'hFFFF, 5'd14, 1'b1, 16'h0003, 2};
        vecs[6] = '{16'hABCD, 5'd16, 1'b1, 16'h0000, 3};
        vecs[7] = '{16'h0001, 5'd15, 1'b0, 16'h8000, 3};
        vecs[8] = '{16'hC3A5, 5'd1,  1'b1, 16'h61D2, 1};
        vecs[9] = '{16'h00F0, 5'd8,  1'b0, 16'hF000, 2};

        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_amount   = '0;
        bus.in_is_right = 1'b0;
        bus.out_ready   = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while the consumer stalls.
        bus.out_ready = 1'b0;
        accept(16'h00F0, 5'd4, 1'b1);
        wait_out(cyc);
        check("bp latency", 32'(cyc), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                bus.in_valid    = 1'b1;
                bus.in_data     = 16'h1111;
                bus.in_amount   = 5'd3;
                bus.in_is_right = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("bp out_valid %0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp out_data %0d", k), 32'(bus.out_data), 32'h000F);
            check($sformatf("bp in_ready %0d", k), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        check("bp release out_data", 32'(bus.out_data), 32'h000F);

        // Reset during the second SHIFT cycle of an amount-20 request.
        accept(16'hBEEF, 5'd20, 1'b0);
        @(posedge clk);
        #1;
        check("rst mid busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        check("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        check("rst mid out_data", 32'(bus.out_data), 32'd0);
        check("rst mid busy_low", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst no out_valid", 32'(seen), 32'd0);
        run_vec(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_shift_sequencer.md
Name: logic_shift_sequencer

Overview:
- Multi-cycle logical shifter with handshakes on both sides. It sits directly upstream of logic_shift and drives its data_in, shift_bit_num and is_right_shift inputs.
- A request may carry a total shift amount larger than one logic_shift pass can apply (max 2^SHIFT_BIT_NUM-1 bits). The sequencer splits it into successive passes, recirculating the registered result each pass, then presents the final word.
- Consumer-side valid/ready output.

Parameters:
- BIT_NUM, 16, data word width.
- SHIFT_BIT_NUM, 3, width of logic_shift shift amount; MAX_STEP = 2^SHIFT_BIT_NUM-1 = 7 bits per pass.
- AMOUNT_BIT_NUM, 5, width of requested total shift amount.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_data  input  BIT_NUM  word to shift.
- in_amount  input  AMOUNT_BIT_NUM  total shift amount, unsigned.
- in_is_right  input  1  1 = logical right shift, 0 = logical left shift; zero fill.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  BIT_NUM  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; out_data=0; busy=0.
  - Internal data_reg=0, remaining=0, dir=0.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - out_data = data_reg, held stable while out_valid=1.
- Accept occurs at a rising edge with in_valid & in_ready:
  - data_reg<=in_data; dir<=in_is_right.
  - remaining<=min(in_amount, BIT_NUM), so amounts >= BIT_NUM clamp to BIT_NUM and the result is all zeros.
  - If the clamped amount is 0, go to DONE; else go to SHIFT.
- SHIFT, each cycle:
  - step = min(remaining, MAX_STEP), computed at AMOUNT_BIT_NUM width, then truncated to SHIFT_BIT_NUM for logic_shift.
  - data_reg<=logic_shift(data_reg, step, dir); remaining<=remaining-step.
  - Go to DONE when remaining==step; otherwise stay in SHIFT.
- DONE: on out_valid & out_ready, go to IDLE. No new accept in the same cycle (one-cycle bubble; in_ready rises the cycle after).
- Latency from the accept edge T0 to out_valid, with clamped amount c:
  - out_valid=1 after edge T0+P, where P = ceil(c/MAX_STEP) shift cycles.
  - c=0: out_valid=1 after edge T0.
- in_* inputs are ignored outside IDLE; the request is captured only at the accept edge.
- Reset asserted mid-SHIFT or mid-DONE: immediately returns to reset values; the in-flight request is discarded and no out_valid is produced.
- Backpressure: out_ready low holds DONE indefinitely; out_data is unchanged and in_ready stays 0.

Decomposition:
- Shared package (logic_shift_pkg):
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - MAX_STEP derivation from SHIFT_BIT_NUM.
- One sub-module: an instance of the existing combinational logic_shift (BIT_NUM, SHIFT_BIT_NUM), fed from data_reg/step/dir, whose data_out loads data_reg.
- FSM, clamp and step logic live in logic_shift_sequencer.

Test Plan:
- 16'hB3C5, amount 10, left, out_ready=1 → passes of 7 then 3; out_valid after edge T0+2 with out_data=16'h1400; in_ready high again the cycle after the handshake.
- 16'h8001, amount 9, right → out_data=16'h0040 after 2 shift cycles (7 then 2).
- 16'hA5A5, amount 0 → out_valid after edge T0 with out_data=16'hA5A5; no logic_shift pass used.
- 16'hFFFF, amount 31, left → clamped to 16; passes 7, 7, 2; out_data=16'h0000 after edge T0+3.
- 16'h00F0, amount 4, right, out_ready=0 for 5 cycles in DONE → out_valid=1 and out_data=16'h000F stable; in_ready=0 and an in_valid pulse is ignored; handshake completes when out_ready=1.
- Assert reset for 1 cycle during the second SHIFT cycle of an amount-20 request → all outputs at reset values; in_ready=1 immediately; no out_valid ever appears for that request; the next request completes correctly.
